script_operand_stack: RTL and testbench
=======================================

# script_operand_stack

Operand stack that feeds the script ALU and absorbs its results, closing the loop around the ALU's operand and result handshake. It holds the script's main stack: it takes literal pushes from the script decoder and pops up to two operands per opcode. It presents those operands on the ALU input strobes, streams further pops on `pop_req`, and writes back the ALU's one or two results when the ALU signals `done` or `error`. The block sits between the script decoder/dispatcher and the ALU.

## Interface
- `DEPTH`, 32: number of stack entries (power of two, ≥4)
- `WIDTH`, 512: entry width in bits
- `clk` in 1: single clock; everything is on the rising edge
- `rst` in 1: synchronous, active-high reset
- `op_valid` in 1: dispatcher issues an opcode
- `op_pops` in 2: operands to pop for the opcode (0..2; 3 is treated as 2)
- `op_ready` out 1: block is in IDLE and can accept `op_valid`
- `push_valid` in 1: decoder pushes a literal
- `push_data` in WIDTH: literal value
- `push_ready` out 1: `op_ready & !op_valid`
- `put_alu_in1` out 1: operand 1 valid; operand 1 is the top of stack (TOS)
- `data_alu_in1` out WIDTH: operand 1
- `put_alu_in2` out 1: operand 2 valid; operand 2 is TOS-1
- `data_alu_in2` out WIDTH: operand 2
- `put_alu_out1` in 1, `data_alu_out1` in WIDTH: ALU result 1
- `put_alu_out2` in 1, `data_alu_out2` in WIDTH: ALU result 2
- `pop_req` in 1: ALU requests one more operand
- `done` in 1: ALU finished the opcode
- `error` in 1: ALU reports script failure
- `op_done` out 1: one-cycle pulse when the opcode retires
- `op_error` out 1: qualifies `op_done`; the opcode failed
- `depth` out $clog2(DEPTH+1): current entry count
- `stack_err` out 1: sticky under/overflow flag, cleared only by `rst`

## Operation
- Storage: a register array `mem[0..DEPTH-1]` with stack pointer `sp` equal to `depth`. TOS is `mem[sp-1]`.
- IDLE:
  - If `op_valid` is high, capture `mem[sp-1]` and `mem[sp-2]` into the operand registers per `op_pops`, set `sp -= op_pops`, and go to EXEC.
  - Otherwise, if `push_valid` is high, write `mem[sp] = push_data` and set `sp += 1`.
  - `op_valid` has priority over `push_valid`.
- Operand valids: `put_alu_in1 = (op_pops ≥ 1)` and `put_alu_in2 = (op_pops == 2)`. Both are held constant through EXEC except when modified by `pop_req`.
- EXEC, checked in this priority order each cycle:
  - `error` high: discard the results, pulse `op_error`, go to IDLE.
  - `done` high, no error: push `data_alu_out1` if `put_alu_out1` is high, then push `data_alu_out2` if `put_alu_out2` is high. Result 2 lands on top. Both pushes are written in the same cycle. Go to IDLE.
  - `pop_req` high: load `data_alu_in1 <= mem[sp-1]` and `sp -= 1`; `data_alu_in2` is unchanged.
- `op_done` pulses in the cycle after the EXEC exit, together with the updated `depth`.
- Underflow on issue (`op_pops > depth`):
  - No EXEC; the stack is unchanged.
  - `op_done` and `op_error` pulse in the next cycle.
  - `stack_err` sets.
- Underflow on `pop_req` at `sp == 0`: `put_alu_in1` drops to 0, `stack_err` sets, and EXEC continues.
- Overflow:
  - A literal push with `sp == DEPTH` is dropped and sets `stack_err`.
  - At commit, a result that does not fit is dropped, sets `stack_err`, and forces `op_error`.
- `push_valid` is ignored outside IDLE; there is no buffering.

## Timing
- Reset values:
  - `sp = 0`, state IDLE.
  - All `put_alu_in*`, `op_done`, `op_error`, and `stack_err` are 0.
  - Operand data registers are 0.
  - `op_ready = 1` from the first cycle after reset.
- `rst` asserted mid-EXEC aborts the opcode. No `op_done` is issued, and stack contents are lost (`sp = 0`).
- Issue accepted in cycle T: operands are valid from T+1. If the ALU answers `done` in cycle E ≥ T+1, then `op_done`, `op_ready`, and the new `depth` appear at E+1. The minimum issue-to-retire latency is 2 cycles.
- `pop_req` in cycle P: the new `data_alu_in1` is valid at P+1. `pop_req` in back-to-back cycles pops one entry per cycle.
- `done` and `pop_req` in the same cycle: `done` wins and the pop is ignored.
- The ALU may hold `done` high. It is sampled only in EXEC, so each opcode retires exactly once.

## Configuration
- `SCRIPT_STACK_GUARD_EN` defined:
  - Under/overflow checks, `stack_err`, and the forced `op_error` are present as described above.
- Not defined:
  - No checks; `stack_err` is tied to 0.
  - `sp` wraps modulo DEPTH on over/underflow, `depth` reports `sp` modulo DEPTH+1, and an issue with `op_pops > depth` proceeds to EXEC with whatever `mem` holds.

## Test plan
- Push `0xAA` then `0xBB`; issue `op_pops=2`; ALU returns `done` with `put_alu_out1=1`, `data=1` two cycles later. Required: in1=`0xBB`, in2=`0xAA`, `op_done` pulse with `op_error=0`, `depth=1`, TOS=1.
- Push `0x5`; issue `op_pops=1`; ALU returns both outputs `0x5` with `done` in the first EXEC cycle. Required: `op_done` 2 cycles after issue, `depth=2`, both entries `0x5`.
- Empty stack, issue `op_pops=1` (guard enabled). Required: no operand valid, `op_done`+`op_error` the next cycle, `stack_err=1`, `depth=0`.
- Push 1, 2, 3; issue `op_pops=1`; ALU pulses `pop_req` for 2 cycles, then asserts `done`. Required: in1 sequence 3, 2, 1; `depth=0` after retire.
- Push `DEPTH` literals, then one more (guard enabled). Required: the last push is dropped, `stack_err=1`, `depth=DEPTH`. Then assert `rst` mid-EXEC of a following op. Required: `depth=0`, no `op_done`, `stack_err=0`.
- Issue `op_pops=2` with `depth=2`; ALU asserts `error` with `done` and `put_alu_out1`. Required: `op_done`+`op_error`, `depth=0`, nothing pushed.

Source files
------------

// File: rtl/script_operand_stack.sv
// Main script stack: feeds ALU operand strobes, streams extra pops and commits ALU results.
// Optional under/overflow guarding (stack_err, forced op_error) is enabled by defining SCRIPT_STACK_GUARD_EN.
module script_operand_stack #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    input  logic [1:0]                   op_pops,
    output logic                         op_ready,
    input  logic                         push_valid,
    input  logic [WIDTH-1:0]             push_data,
    output logic                         push_ready,
    output logic                         put_alu_in1,
    output logic [WIDTH-1:0]             data_alu_in1,
    output logic                         put_alu_in2,
    output logic [WIDTH-1:0]             data_alu_in2,
    input  logic                         put_alu_out1,
    input  logic [WIDTH-1:0]             data_alu_out1,
    input  logic                         put_alu_out2,
    input  logic [WIDTH-1:0]             data_alu_out2,
    input  logic                         pop_req,
    input  logic                         done,
    input  logic                         error,
    output logic                         op_done,
    output logic                         op_error,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         stack_err
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};
    localparam logic [SPW-1:0] SP_ONE  = {{(SPW-1){1'b0}}, 1'b1};
    localparam logic [SPW-1:0] SP_MAX  = SPW'(DEPTH);
`ifdef SCRIPT_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;

    // Without guarding the pointer wraps modulo DEPTH; with guarding the wrap is never reached.
    function automatic logic [SPW-1:0] sp_inc(input logic [SPW-1:0] sp);
        if (sp == SP_MAX) sp_inc = SP_ONE;
        else              sp_inc = sp + SP_ONE;
    endfunction

    function automatic logic [SPW-1:0] sp_dec(input logic [SPW-1:0] sp);
        if (sp == SP_ZERO) sp_dec = SP_MAX - SP_ONE;
        else               sp_dec = sp - SP_ONE;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state_r, state_s;
    logic [SPW-1:0]   sp_r, sp_s, sp_m1_s, sp_m2_s, pops_ext_s, commit_sp_s;
    logic [1:0]       pops_eff_s;
    logic [WIDTH-1:0] in1_r, in1_s, in2_r, in2_s;
    logic             put1_r, put1_s, put2_r, put2_s;
    logic             op_done_r, op_done_s, op_error_r, op_error_s, err_r, err_s;
    logic             commit_drop_s;
    logic             wr0_en_s, wr1_en_s;
    logic [AW-1:0]    wr0_idx_s, wr1_idx_s;
    logic [WIDTH-1:0] wr0_data_s, wr1_data_s;

    assign pops_eff_s = (op_pops == 2'd3) ? 2'd2 : op_pops;
    assign pops_ext_s = {{(SPW-2){1'b0}}, pops_eff_s};
    assign sp_m1_s    = sp_dec(sp_r);
    assign sp_m2_s    = sp_dec(sp_m1_s);

    assign op_ready     = (state_r == ST_IDLE);
    assign push_ready   = op_ready & ~op_valid;
    assign put_alu_in1  = put1_r;
    assign put_alu_in2  = put2_r;
    assign data_alu_in1 = in1_r;
    assign data_alu_in2 = in2_r;
    assign op_done      = op_done_r;
    assign op_error     = op_error_r;
    assign depth        = sp_r;
    assign stack_err    = err_r;

    // Next-state, pointer, operand and write-port decode.
    always_comb begin
        state_s       = state_r;
        sp_s          = sp_r;
        in1_s         = in1_r;
        in2_s         = in2_r;
        put1_s        = put1_r;
        put2_s        = put2_r;
        op_done_s     = 1'b0;
        op_error_s    = 1'b0;
        err_s         = err_r;
        commit_sp_s   = sp_r;
        commit_drop_s = 1'b0;
        wr0_en_s      = 1'b0;
        wr0_idx_s     = {AW{1'b0}};
        wr0_data_s    = {WIDTH{1'b0}};
        wr1_en_s      = 1'b0;
        wr1_idx_s     = {AW{1'b0}};
        wr1_data_s    = {WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (op_valid) begin
                    if (GUARD && (pops_ext_s > sp_r)) begin
                        op_done_s  = 1'b1;
                        op_error_s = 1'b1;
                        err_s      = 1'b1;
                        put1_s     = 1'b0;
                        put2_s     = 1'b0;
                    end else begin
                        state_s = ST_EXEC;
                        put1_s  = (pops_eff_s != 2'd0);
                        put2_s  = (pops_eff_s == 2'd2);
                        in1_s   = (pops_eff_s != 2'd0) ? mem[sp_m1_s[AW-1:0]] : {WIDTH{1'b0}};
                        in2_s   = (pops_eff_s == 2'd2) ? mem[sp_m2_s[AW-1:0]] : {WIDTH{1'b0}};
                        case (pops_eff_s)
                            2'd1:    sp_s = sp_m1_s;
                            2'd2:    sp_s = sp_m2_s;
                            default: sp_s = sp_r;
                        endcase
                    end
                end else if (push_valid) begin
                    if (GUARD && (sp_r == SP_MAX)) begin
                        err_s = 1'b1;
                    end else begin
                        wr0_en_s   = 1'b1;
                        wr0_idx_s  = sp_r[AW-1:0];
                        wr0_data_s = push_data;
                        sp_s       = sp_inc(sp_r);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (error) begin
                    state_s    = ST_IDLE;
                    op_done_s  = 1'b1;
                    op_error_s = 1'b1;
                    put1_s     = 1'b0;
                    put2_s     = 1'b0;
                end else if (done) begin
                    state_s = ST_IDLE;
                    put1_s  = 1'b0;
                    put2_s  = 1'b0;
                    // Result 1 goes in first so result 2 ends up on top.
                    if (put_alu_out1) begin
                        if (GUARD && (commit_sp_s == SP_MAX)) begin
                            commit_drop_s = 1'b1;
                        end else begin
                            wr0_en_s    = 1'b1;
                            wr0_idx_s   = commit_sp_s[AW-1:0];
                            wr0_data_s  = data_alu_out1;
                            commit_sp_s = sp_inc(commit_sp_s);
                        end
                    end else begin
                        commit_drop_s = 1'b0;
                    end
                    if (put_alu_out2) begin
                        if (GUARD && (commit_sp_s == SP_MAX)) begin
                            commit_drop_s = 1'b1;
                        end else begin
                            wr1_en_s    = 1'b1;
                            wr1_idx_s   = commit_sp_s[AW-1:0];
                            wr1_data_s  = data_alu_out2;
                            commit_sp_s = sp_inc(commit_sp_s);
                        end
                    end else begin
                        wr1_en_s = 1'b0;
                    end
                    sp_s       = commit_sp_s;
                    op_done_s  = 1'b1;
                    op_error_s = commit_drop_s;
                    err_s      = err_r | commit_drop_s;
                end else if (pop_req) begin
                    if (GUARD && (sp_r == SP_ZERO)) begin
                        put1_s = 1'b0;
                        err_s  = 1'b1;
                    end else begin
                        in1_s  = mem[sp_m1_s[AW-1:0]];
                        put1_s = 1'b1;
                        sp_s   = sp_m1_s;
                    end
                end else begin
                    state_s = ST_EXEC;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Control and operand registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            sp_r       <= SP_ZERO;
            in1_r      <= {WIDTH{1'b0}};
            in2_r      <= {WIDTH{1'b0}};
            put1_r     <= 1'b0;
            put2_r     <= 1'b0;
            op_done_r  <= 1'b0;
            op_error_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            sp_r       <= sp_s;
            in1_r      <= in1_s;
            in2_r      <= in2_s;
            put1_r     <= put1_s;
            put2_r     <= put2_s;
            op_done_r  <= op_done_s;
            op_error_r <= op_error_s;
            err_r      <= err_s;
        end
    end

    // Stack storage; two write ports so both ALU results commit in one cycle.
    always_ff @(posedge clk) begin
        if (!rst && wr0_en_s) mem[wr0_idx_s] <= wr0_data_s;
        if (!rst && wr1_en_s) mem[wr1_idx_s] <= wr1_data_s;
    end

endmodule

// File: tb/tb_script_operand_stack.sv
// Directed self-checking bench for script_operand_stack; guard-only checks follow SCRIPT_STACK_GUARD_EN.
module tb_script_operand_stack;

    localparam int DEPTH = 32;
    localparam int WIDTH = 512;
    localparam int DW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic op_valid = 1'b0;
    logic [1:0] op_pops = 2'd0;
    logic op_ready;
    logic push_valid = 1'b0;
    logic [WIDTH-1:0] push_data = '0;
    logic push_ready;
    logic put_alu_in1, put_alu_in2;
    logic [WIDTH-1:0] data_alu_in1, data_alu_in2;
    logic put_alu_out1 = 1'b0, put_alu_out2 = 1'b0;
    logic [WIDTH-1:0] data_alu_out1 = '0, data_alu_out2 = '0;
    logic pop_req = 1'b0, done = 1'b0, error = 1'b0;
    logic op_done, op_error, stack_err;
    logic [DW-1:0] depth;

    int n_cmp = 0;
    int n_mis = 0;

    script_operand_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_pops(op_pops), .op_ready(op_ready),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .put_alu_in1(put_alu_in1), .data_alu_in1(data_alu_in1),
        .put_alu_in2(put_alu_in2), .data_alu_in2(data_alu_in2),
        .put_alu_out1(put_alu_out1), .data_alu_out1(data_alu_out1),
        .put_alu_out2(put_alu_out2), .data_alu_out2(data_alu_out2),
        .pop_req(pop_req), .done(done), .error(error),
        .op_done(op_done), .op_error(op_error), .depth(depth), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        push_valid = 1'b1;
        push_data  = v;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] p);
        op_valid = 1'b1;
        op_pops  = p;
        tick();
        op_valid = 1'b0;
        op_pops  = 2'd0;
    endtask

    task automatic retire(input logic o1, input logic [WIDTH-1:0] d1, input logic o2, input logic [WIDTH-1:0] d2);
        done = 1'b1; put_alu_out1 = o1; data_alu_out1 = d1; put_alu_out2 = o2; data_alu_out2 = d2;
        tick();
        done = 1'b0; put_alu_out1 = 1'b0; put_alu_out2 = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_op_ready", op_ready, 1);
        chk("rst_push_ready", push_ready, 1);
        chk("rst_depth", depth, 0);
        chk("rst_put_in1", put_alu_in1, 0);
        chk("rst_put_in2", put_alu_in2, 0);
        chk("rst_data_in1", data_alu_in1, 0);
        chk("rst_data_in2", data_alu_in2, 0);
        chk("rst_op_done", op_done, 0);
        chk("rst_stack_err", stack_err, 0);

        // Two literals, binary op, single result.
        push(512'hAA);
        push(512'hBB);
        chk("t1_depth_pushed", depth, 2);
        issue(2'd2);
        chk("t1_in1", data_alu_in1, 512'hBB);
        chk("t1_in2", data_alu_in2, 512'hAA);
        chk("t1_put_in1", put_alu_in1, 1);
        chk("t1_put_in2", put_alu_in2, 1);
        chk("t1_depth_exec", depth, 0);
        chk("t1_busy", op_ready, 0);
        tick();
        chk("t1_no_early_done", op_done, 0);
        retire(1'b1, 512'h1, 1'b0, 512'h0);
        chk("t1_op_done", op_done, 1);
        chk("t1_op_error", op_error, 0);
        chk("t1_depth", depth, 1);
        chk("t1_ready", op_ready, 1);
        issue(2'd1);
        chk("t1_tos", data_alu_in1, 512'h1);
        retire(1'b0, 512'h0, 1'b0, 512'h0);
        chk("t1_drain_depth", depth, 0);

        // Unary op, two results in the first EXEC cycle.
        push(512'h5);
        issue(2'd1);
        chk("t2_in1", data_alu_in1, 512'h5);
        chk("t2_put_in2", put_alu_in2, 0);
        retire(1'b1, 512'h5, 1'b1, 512'h5);
        chk("t2_op_done", op_done, 1);
        chk("t2_depth", depth, 2);

        // Both entries are 5; ALU then reports error together with done.
        issue(2'd3);
        chk("t6_in1", data_alu_in1, 512'h5);
        chk("t6_in2", data_alu_in2, 512'h5);
        done = 1'b1; error = 1'b1; put_alu_out1 = 1'b1; data_alu_out1 = 512'h77;
        tick();
        error = 1'b0; put_alu_out1 = 1'b0;
        chk("t6_op_done", op_done, 1);
        chk("t6_op_error", op_error, 1);
        chk("t6_depth", depth, 0);
        tick();
        done = 1'b0;
        chk("t6_held_done_once", op_done, 0);
        chk("t6_held_depth", depth, 0);

        // Streaming pops, then done together with pop_req.
        push(512'h1);
        push(512'h2);
        push(512'h3);
        issue(2'd1);
        chk("t4_in1_a", data_alu_in1, 512'h3);
        chk("t4_depth_a", depth, 2);
        pop_req = 1'b1;
        tick();
        chk("t4_in1_b", data_alu_in1, 512'h2);
        chk("t4_depth_b", depth, 1);
        tick();
        chk("t4_in1_c", data_alu_in1, 512'h1);
        chk("t4_depth_c", depth, 0);
        retire(1'b0, 512'h0, 1'b0, 512'h0);
        pop_req = 1'b0;
        chk("t4_op_done", op_done, 1);
        chk("t4_depth", depth, 0);
        chk("t4_no_err", stack_err, 0);

        // Fill the stack, then reset in the middle of an opcode.
        for (int i = 0; i < DEPTH; i++) push(WIDTH'(i + 1));
        chk("t5_full_depth", depth, DEPTH);
`ifdef SCRIPT_STACK_GUARD_EN
        push(512'hDEAD);
        chk("t5_of_depth", depth, DEPTH);
        chk("t5_of_err", stack_err, 1);
`endif
        issue(2'd2);
        chk("t5_in1", data_alu_in1, DEPTH);
        chk("t5_in2", data_alu_in2, DEPTH - 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_depth", depth, 0);
        chk("t5_rst_no_done", op_done, 0);
        chk("t5_rst_err", stack_err, 0);
        chk("t5_rst_ready", op_ready, 1);
        tick();
        chk("t5_rst_no_done_late", op_done, 0);

`ifdef SCRIPT_STACK_GUARD_EN
        // Underflow on issue from an empty stack.
        issue(2'd1);
        chk("t3_op_done", op_done, 1);
        chk("t3_op_error", op_error, 1);
        chk("t3_put_in1", put_alu_in1, 0);
        chk("t3_stack_err", stack_err, 1);
        chk("t3_depth", depth, 0);
        chk("t3_ready", op_ready, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
